credit_switch_allocator: RTL and testbench
==========================================

CREDIT_SWITCH_ALLOCATOR -- requirements
Module: credit_switch_allocator

Interface
REQ-001 SHALL have parameter PORT_NUM, default 5, number of router input and output ports.
REQ-002 SHALL have parameter VC_NUM, default 2, virtual channels per port.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4, downstream flit slots per VC (initial credits).
REQ-004 SHALL have parameter PACKET_LOCK, default 1; 1 = hold output from head to tail, 0 = flit-level allocation.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port switch_request_i, input, [PORT_NUM][VC_NUM], input VC holds a flit ready for traversal.
REQ-008 SHALL have port out_port_i, input, [PORT_NUM][VC_NUM] x PORT_SIZE, requested output port.
REQ-009 SHALL have port downstream_vc_i, input, [PORT_NUM][VC_NUM] x VC_SIZE, allocated downstream VC.
REQ-010 SHALL have port is_tail_i, input, [PORT_NUM][VC_NUM], requesting flit is a tail (single-flit packets: 1).
REQ-011 SHALL have port credit_i, input, [PORT_NUM][VC_NUM], one-cycle credit return per output port and downstream VC.
REQ-012 SHALL have port valid_sel_o, output, [PORT_NUM], input port granted.
REQ-013 SHALL have port vc_sel_o, output, [PORT_NUM] x VC_SIZE, granted input VC per input port.
REQ-014 SHALL have port xbar_sel_o, output, [PORT_NUM] x PORT_SIZE, input port driving each output.
REQ-015 SHALL have port xbar_valid_o, output, [PORT_NUM], output port carries a flit.
REQ-016 SHALL have port credit_error_o, output, 1, sticky credit overflow flag.

Function
REQ-017 SHALL treat (p,v) as eligible when switch_request_i is 1 and credit counter of (out_port_i, downstream_vc_i) is nonzero.
REQ-018 SHALL pick at most one eligible VC per input port by round-robin (stage 1), then at most one stage-1 winner per output port by round-robin (stage 2).
REQ-019 SHALL advance a stage-1 pointer to one past the winner only when that winner also wins stage 2; stage-2 pointers advance one past the granted input on every grant.
REQ-020 SHALL register all grant outputs: grants computed from inputs at edge N appear on outputs after edge N and hold exactly one cycle.
REQ-021 SHALL decrement the targeted credit counter on the same edge the grant is registered, so requests in the next cycle see the reduced count.
REQ-022 SHALL increment a counter on credit_i; grant and credit_i on the same counter in one cycle leave it unchanged.
REQ-023 SHALL saturate a counter at BUFFER_DEPTH on credit_i when full and set credit_error_o until reset.
REQ-024 SHALL, with PACKET_LOCK=1, lock an output to (input, VC) when granting a flit with is_tail_i=0; a granted tail releases the lock at that edge.
REQ-025 SHALL, while an output is locked, grant it only to the owning (input, VC); other requests for it are ineligible in stage 1.
REQ-026 SHALL never grant one input port twice or one output port twice in a cycle.

Reset
REQ-027 SHALL, while rst=0 at an edge, clear all outputs, RR pointers, locks and credit_error_o, and load all counters with BUFFER_DEPTH; reset mid-packet drops locks.

Structure
REQ-028 SHALL take PORT_SIZE, VC_SIZE and CREDIT_SIZE=$clog2(BUFFER_DEPTH+1) from noc_params.
REQ-029 SHALL instantiate sub-module rr_update_arbiter (N requests, one-hot grant, update_i-gated pointer) for both stages.

Verification
REQ-030 SHALL check reset: rst=0 for 2 cycles -> all outputs 0, credit_error_o=0.
REQ-031 SHALL check credits: in0/VC1 -> out2/dVC1, tail=1, no credit_i -> grants 4 consecutive cycles, none 5th; one credit_i -> exactly one more grant.
REQ-032 SHALL check fairness: in1 and in3 to out4 continuously, credits returned each cycle -> xbar_sel_o[4] alternates 1,3,1,3.
REQ-033 SHALL check locking: in0 head (tail=0) to out2, in1 competing for out2 -> in1 blocked until in0 tail granted, granted next cycle.
REQ-034 SHALL check credit boundaries: grant plus credit_i same counter -> count unchanged; credit_i at count 4 -> credit_error_o=1 until reset.
REQ-035 SHALL check reset mid-packet: rst=0 while out2 locked -> after reset in1 granted out2 first cycle.

Source files
------------

// File: rtl/noc_params.sv
// Shared sizing defaults and width helpers for the NoC switch allocator.
package noc_params;

    localparam int unsigned DEF_PORT_NUM     = 5;
    localparam int unsigned DEF_VC_NUM       = 2;
    localparam int unsigned DEF_BUFFER_DEPTH = 4;
    localparam int unsigned DEF_PACKET_LOCK  = 1;

    // Width of an index selecting one of n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..depth.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_update_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves one past the winner only when update_i is asserted.
module rr_update_arbiter
    import noc_params::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic [N-1:0]  w_grant;
    logic          w_hit;

    // First requester at or after the pointer, wrapping around to index 0.
    always_comb begin
        w_grant    = '0;
        w_hit      = 1'b0;
        w_next_ptr = r_ptr;
        for (int unsigned j = 0; j < N; j++) begin
            if (!w_hit && request_i[j] && (j >= 32'(r_ptr))) begin
                w_grant[j] = 1'b1;
                w_hit      = 1'b1;
                w_next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!w_hit && request_i[j] && (j < 32'(r_ptr))) begin
                w_grant[j] = 1'b1;
                w_hit      = 1'b1;
                w_next_ptr = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    // Pointer register, advanced only on a confirmed grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (update_i && w_hit) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign grant_o = w_grant;

endmodule

// File: rtl/credit_switch_allocator.sv
// Two-stage separable switch allocator with per-(output, downstream VC)
// credit counters and optional packet-level output locking.
module credit_switch_allocator
    import noc_params::*;
#(
    parameter  int unsigned PORT_NUM     = DEF_PORT_NUM,
    parameter  int unsigned VC_NUM       = DEF_VC_NUM,
    parameter  int unsigned BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter  int unsigned PACKET_LOCK  = DEF_PACKET_LOCK,
    localparam int unsigned PORT_SIZE    = idx_width(PORT_NUM),
    localparam int unsigned VC_SIZE      = idx_width(VC_NUM),
    localparam int unsigned CREDIT_SIZE  = credit_width(BUFFER_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [PORT_NUM*VC_NUM-1:0]            switch_request_i,
    input  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0]  out_port_i,
    input  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]    downstream_vc_i,
    input  logic [PORT_NUM*VC_NUM-1:0]            is_tail_i,
    input  logic [PORT_NUM*VC_NUM-1:0]            credit_i,
    output logic [PORT_NUM-1:0]                   valid_sel_o,
    output logic [PORT_NUM*VC_SIZE-1:0]           vc_sel_o,
    output logic [PORT_NUM*PORT_SIZE-1:0]         xbar_sel_o,
    output logic [PORT_NUM-1:0]                   xbar_valid_o,
    output logic                                  credit_error_o
);

    // Unpacked views of the flat input buses
    logic                   w_req      [PORT_NUM][VC_NUM];
    logic [PORT_SIZE-1:0]   w_out      [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]     w_dvc      [PORT_NUM][VC_NUM];
    logic                   w_tail     [PORT_NUM][VC_NUM];
    logic                   w_cin      [PORT_NUM][VC_NUM];

    // Stage 1 (per input port)
    logic [VC_NUM-1:0]      w_elig     [PORT_NUM];
    logic [VC_NUM-1:0]      w_s1_grant [PORT_NUM];
    logic                   w_s1_valid [PORT_NUM];
    logic [VC_SIZE-1:0]     w_s1_vc    [PORT_NUM];
    logic [PORT_SIZE-1:0]   w_s1_out   [PORT_NUM];
    logic [VC_SIZE-1:0]     w_s1_dvc   [PORT_NUM];
    logic                   w_s1_tail  [PORT_NUM];
    logic                   w_s1_win   [PORT_NUM];

    // Stage 2 (per output port)
    logic [PORT_NUM-1:0]    w_s2_req   [PORT_NUM];
    logic                   w_s2_any   [PORT_NUM];
    logic [PORT_NUM-1:0]    w_s2_grant [PORT_NUM];
    logic                   w_xv       [PORT_NUM];
    logic [PORT_SIZE-1:0]   w_xsel     [PORT_NUM];
    logic [VC_SIZE-1:0]     w_g_vc     [PORT_NUM];
    logic [VC_SIZE-1:0]     w_g_dvc    [PORT_NUM];
    logic                   w_g_tail   [PORT_NUM];
    logic                   w_dec      [PORT_NUM][VC_NUM];

    // State
    logic [CREDIT_SIZE-1:0] r_credit     [PORT_NUM][VC_NUM];
    logic                   r_err;
    logic                   r_lock_valid [PORT_NUM];
    logic [PORT_SIZE-1:0]   r_lock_in    [PORT_NUM];
    logic [VC_SIZE-1:0]     r_lock_vc    [PORT_NUM];
    logic                   r_valid_sel  [PORT_NUM];
    logic [VC_SIZE-1:0]     r_vc_sel     [PORT_NUM];
    logic [PORT_SIZE-1:0]   r_xbar_sel   [PORT_NUM];
    logic                   r_xbar_valid [PORT_NUM];

    genvar gp, gv;
    generate
        for (gp = 0; gp < PORT_NUM; gp++) begin : g_port
            for (gv = 0; gv < VC_NUM; gv++) begin : g_vc
                assign w_req[gp][gv]  = switch_request_i[gp*VC_NUM + gv];
                assign w_out[gp][gv]  = out_port_i[(gp*VC_NUM + gv)*PORT_SIZE +: PORT_SIZE];
                assign w_dvc[gp][gv]  = downstream_vc_i[(gp*VC_NUM + gv)*VC_SIZE +: VC_SIZE];
                assign w_tail[gp][gv] = is_tail_i[gp*VC_NUM + gv];
                // credit_i is indexed by (output port, downstream VC)
                assign w_cin[gp][gv]  = credit_i[gp*VC_NUM + gv];
            end

            rr_update_arbiter #(.N(VC_NUM)) u_stage1 (
                .clk       (clk),
                .rst       (rst),
                .request_i (w_elig[gp]),
                .update_i  (w_s1_win[gp]),
                .grant_o   (w_s1_grant[gp])
            );

            rr_update_arbiter #(.N(PORT_NUM)) u_stage2 (
                .clk       (clk),
                .rst       (rst),
                .request_i (w_s2_req[gp]),
                .update_i  (w_s2_any[gp]),
                .grant_o   (w_s2_grant[gp])
            );

            assign valid_sel_o[gp]                         = r_valid_sel[gp];
            assign vc_sel_o[gp*VC_SIZE +: VC_SIZE]         = r_vc_sel[gp];
            assign xbar_sel_o[gp*PORT_SIZE +: PORT_SIZE]   = r_xbar_sel[gp];
            assign xbar_valid_o[gp]                        = r_xbar_valid[gp];
        end
    endgenerate

    assign credit_error_o = r_err;

    // Eligibility: request, credit on the target downstream VC, and lock ownership.
    always_comb begin
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                w_elig[p][v] = 1'b0;
                for (int unsigned o = 0; o < PORT_NUM; o++) begin
                    for (int unsigned d = 0; d < VC_NUM; d++) begin
                        if ((w_out[p][v] == PORT_SIZE'(o)) && (w_dvc[p][v] == VC_SIZE'(d))) begin
                            w_elig[p][v] = w_req[p][v] && (r_credit[o][d] != '0) &&
                                           (!r_lock_valid[o] ||
                                            ((r_lock_in[o] == PORT_SIZE'(p)) &&
                                             (r_lock_vc[o] == VC_SIZE'(v))));
                        end
                    end
                end
            end
        end
    end

    // Decode the stage-1 winner of each input port into its request fields.
    always_comb begin
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            w_s1_valid[p] = |w_s1_grant[p];
            w_s1_vc[p]    = '0;
            w_s1_out[p]   = '0;
            w_s1_dvc[p]   = '0;
            w_s1_tail[p]  = 1'b0;
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (w_s1_grant[p][v]) begin
                    w_s1_vc[p]   = VC_SIZE'(v);
                    w_s1_out[p]  = w_out[p][v];
                    w_s1_dvc[p]  = w_dvc[p][v];
                    w_s1_tail[p] = w_tail[p][v];
                end
            end
        end
    end

    // Route stage-1 winners to the stage-2 arbiter of their requested output.
    always_comb begin
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            w_s2_req[o] = '0;
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                w_s2_req[o][p] = w_s1_valid[p] && (w_s1_out[p] == PORT_SIZE'(o));
            end
            w_s2_any[o] = |w_s2_req[o];
        end
    end

    // Decode stage-2 grants into crossbar selects and per-input confirmation.
    always_comb begin
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            w_s1_win[p] = 1'b0;
        end
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            w_xv[o]     = 1'b0;
            w_xsel[o]   = '0;
            w_g_vc[o]   = '0;
            w_g_dvc[o]  = '0;
            w_g_tail[o] = 1'b0;
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
                if (w_s2_grant[o][p]) begin
                    w_s1_win[p] = 1'b1;
                    w_xv[o]     = 1'b1;
                    w_xsel[o]   = PORT_SIZE'(p);
                    w_g_vc[o]   = w_s1_vc[p];
                    w_g_dvc[o]  = w_s1_dvc[p];
                    w_g_tail[o] = w_s1_tail[p];
                end
            end
        end
    end

    // Credit consumed by this cycle's grant, per (output, downstream VC).
    always_comb begin
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            for (int unsigned d = 0; d < VC_NUM; d++) begin
                w_dec[o][d] = w_xv[o] && (w_g_dvc[o] == VC_SIZE'(d));
            end
        end
    end

    // Register the grant outputs for exactly one cycle.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (!rst) begin
                r_valid_sel[p]  <= 1'b0;
                r_vc_sel[p]     <= '0;
                r_xbar_sel[p]   <= '0;
                r_xbar_valid[p] <= 1'b0;
            end else begin
                r_valid_sel[p]  <= w_s1_win[p];
                r_vc_sel[p]     <= w_s1_win[p] ? w_s1_vc[p] : '0;
                r_xbar_sel[p]   <= w_xsel[p];
                r_xbar_valid[p] <= w_xv[p];
            end
        end
    end

    // Credit counters: grant consumes, credit_i returns, saturate with sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                for (int unsigned d = 0; d < VC_NUM; d++) begin
                    r_credit[o][d] <= CREDIT_SIZE'(BUFFER_DEPTH);
                end
            end
        end else begin
            for (int unsigned o = 0; o < PORT_NUM; o++) begin
                for (int unsigned d = 0; d < VC_NUM; d++) begin
                    if (w_dec[o][d] && !w_cin[o][d]) begin
                        r_credit[o][d] <= r_credit[o][d] - 1'b1;
                    end else if (w_cin[o][d] && !w_dec[o][d]) begin
                        if (r_credit[o][d] == CREDIT_SIZE'(BUFFER_DEPTH)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_credit[o][d] <= r_credit[o][d] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output locks: a granted head/body flit claims the output, a granted tail frees it.
    always_ff @(posedge clk) begin
        for (int unsigned o = 0; o < PORT_NUM; o++) begin
            if (!rst) begin
                r_lock_valid[o] <= 1'b0;
                r_lock_in[o]    <= '0;
                r_lock_vc[o]    <= '0;
            end else if ((PACKET_LOCK != 0) && w_xv[o]) begin
                if (w_g_tail[o]) begin
                    r_lock_valid[o] <= 1'b0;
                end else begin
                    r_lock_valid[o] <= 1'b1;
                    r_lock_in[o]    <= w_xsel[o];
                    r_lock_vc[o]    <= w_g_vc[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Scoreboard bench for credit_switch_allocator: the driver predicts each
// cycle's registered outputs from a behavioural model and queues them; the
// monitor pops and compares one entry after every clock edge.
module tb_credit_switch_allocator;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int B  = 4;
    localparam int PS = 3;
    localparam int VS = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [P*V-1:0]    switch_request_i = '0;
    logic [P*V*PS-1:0] out_port_i = '0;
    logic [P*V*VS-1:0] downstream_vc_i = '0;
    logic [P*V-1:0]    is_tail_i = '0;
    logic [P*V-1:0]    credit_i = '0;
    logic [P-1:0]      valid_sel_o;
    logic [P*VS-1:0]   vc_sel_o;
    logic [P*PS-1:0]   xbar_sel_o;
    logic [P-1:0]      xbar_valid_o;
    logic              credit_error_o;

    credit_switch_allocator #(
        .PORT_NUM     (P),
        .VC_NUM       (V),
        .BUFFER_DEPTH (B),
        .PACKET_LOCK  (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .switch_request_i (switch_request_i),
        .out_port_i       (out_port_i),
        .downstream_vc_i  (downstream_vc_i),
        .is_tail_i        (is_tail_i),
        .credit_i         (credit_i),
        .valid_sel_o      (valid_sel_o),
        .vc_sel_o         (vc_sel_o),
        .xbar_sel_o       (xbar_sel_o),
        .xbar_valid_o     (xbar_valid_o),
        .credit_error_o   (credit_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]    vs;
        logic [P*VS-1:0] vc;
        logic [P*PS-1:0] xs;
        logic [P-1:0]    xv;
        logic            err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   mon_cyc  = 0;

    // Stimulus for the next cycle
    int a_rst;
    int a_req [P][V];
    int a_out [P][V];
    int a_dvc [P][V];
    int a_tail[P][V];
    int a_cred[P][V];   // indexed [output port][downstream VC]

    // Reference model state
    int m_cred [P][V];
    int m_lockv[P];
    int m_lockp[P];
    int m_lockvc[P];
    int m_ptr1 [P];
    int m_ptr2 [P];
    int m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, mon_cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                a_req[p][v] = 0; a_out[p][v] = 0; a_dvc[p][v] = 0;
                a_tail[p][v] = 0; a_cred[p][v] = 0;
            end
        end
    endtask

    function automatic bit eligible(int p, int v);
        int o, d;
        o = a_out[p][v];
        d = a_dvc[p][v];
        if (a_req[p][v] == 0) return 1'b0;
        if (m_cred[o][d] <= 0) return 1'b0;
        if (m_lockv[o] != 0 && !(m_lockp[o] == p && m_lockvc[o] == v)) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step();
        exp_t e;
        int   w1[P];
        int   w2[P];
        int   dec[P][V];
        @(negedge clk);
        rst = (a_rst != 0);
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                switch_request_i[p*V+v]       = (a_req[p][v] != 0);
                out_port_i[(p*V+v)*PS +: PS]  = PS'(a_out[p][v]);
                downstream_vc_i[(p*V+v)*VS +: VS] = VS'(a_dvc[p][v]);
                is_tail_i[p*V+v]              = (a_tail[p][v] != 0);
                credit_i[p*V+v]               = (a_cred[p][v] != 0);
            end
        end
        e.vs = '0; e.vc = '0; e.xs = '0; e.xv = '0; e.err = 1'b0;
        if (a_rst == 0) begin
            for (int o = 0; o < P; o++) begin
                for (int d = 0; d < V; d++) m_cred[o][d] = B;
                m_lockv[o] = 0; m_lockp[o] = 0; m_lockvc[o] = 0;
                m_ptr1[o] = 0; m_ptr2[o] = 0;
            end
            m_err = 0;
        end else begin
            for (int p = 0; p < P; p++) begin
                w1[p] = -1;
                for (int k = 0; k < V; k++) begin
                    if (w1[p] < 0 && eligible(p, (m_ptr1[p] + k) % V)) w1[p] = (m_ptr1[p] + k) % V;
                end
            end
            for (int o = 0; o < P; o++) begin
                w2[o] = -1;
                for (int d = 0; d < V; d++) dec[o][d] = 0;
                for (int k = 0; k < P; k++) begin
                    int p;
                    p = (m_ptr2[o] + k) % P;
                    if (w2[o] < 0 && w1[p] >= 0 && a_out[p][w1[p]] == o) w2[o] = p;
                end
            end
            for (int o = 0; o < P; o++) begin
                if (w2[o] >= 0) begin
                    int p, v;
                    p = w2[o];
                    v = w1[p];
                    e.xv[o] = 1'b1;
                    e.xs[o*PS +: PS] = PS'(p);
                    e.vs[p] = 1'b1;
                    e.vc[p*VS +: VS] = VS'(v);
                    m_ptr2[o] = (p + 1) % P;
                    m_ptr1[p] = (v + 1) % V;
                    dec[o][a_dvc[p][v]] = 1;
                    if (a_tail[p][v] != 0) begin
                        m_lockv[o] = 0;
                    end else begin
                        m_lockv[o] = 1; m_lockp[o] = p; m_lockvc[o] = v;
                    end
                end
            end
            for (int o = 0; o < P; o++) begin
                for (int d = 0; d < V; d++) begin
                    if (dec[o][d] != 0 && a_cred[o][d] == 0) begin
                        m_cred[o][d]--;
                    end else if (a_cred[o][d] != 0 && dec[o][d] == 0) begin
                        if (m_cred[o][d] == B) m_err = 1;
                        else m_cred[o][d]++;
                    end
                end
            end
            e.err = (m_err != 0);
        end
        sb_q.push_back(e);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compare DUT outputs against the queued prediction after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mon_cyc++;
            chk("valid_sel",    32'(valid_sel_o),    32'(e.vs));
            chk("vc_sel",       32'(vc_sel_o),       32'(e.vc));
            chk("xbar_sel",     32'(xbar_sel_o),     32'(e.xs));
            chk("xbar_valid",   32'(xbar_valid_o),   32'(e.xv));
            chk("credit_error", 32'(credit_error_o), 32'(e.err));
        end
    end

    initial begin
        clear_inputs();
        // Reset held for two cycles
        a_rst = 0; steps(2);
        a_rst = 1;

        // Credits: in0/VC1 -> out2/dVC1 drains 4 credits, then one returned
        a_req[0][1] = 1; a_out[0][1] = 2; a_dvc[0][1] = 1; a_tail[0][1] = 1;
        steps(6);
        a_cred[2][1] = 1; step();
        a_cred[2][1] = 0; steps(3);

        // Fairness: in1 and in3 compete for out4 with credits returned every cycle
        a_rst = 0; step(); a_rst = 1;
        clear_inputs();
        a_req[1][0] = 1; a_out[1][0] = 4; a_tail[1][0] = 1;
        a_req[3][0] = 1; a_out[3][0] = 4; a_tail[3][0] = 1;
        a_cred[4][0] = 1;
        steps(8);

        // Locking: in0 packet holds out2 until its tail, in1 waits
        a_rst = 0; step(); a_rst = 1;
        clear_inputs();
        a_req[0][0] = 1; a_out[0][0] = 2; a_dvc[0][0] = 0; a_tail[0][0] = 0;
        a_req[1][0] = 1; a_out[1][0] = 2; a_dvc[1][0] = 1; a_tail[1][0] = 1;
        steps(3);
        a_tail[0][0] = 1; step();
        a_req[0][0] = 0; steps(3);

        // Credit boundaries: grant + return leaves count; return at full flags error
        a_rst = 0; step(); a_rst = 1;
        clear_inputs();
        a_req[2][0] = 1; a_out[2][0] = 0; a_tail[2][0] = 1; a_cred[0][0] = 1;
        steps(4);
        a_req[2][0] = 0; step();
        a_cred[0][0] = 0; steps(3);
        a_rst = 0; step(); a_rst = 1;
        steps(2);

        // Reset mid-packet drops the lock on out2
        clear_inputs();
        a_req[0][0] = 1; a_out[0][0] = 2; a_tail[0][0] = 0;
        a_req[1][0] = 1; a_out[1][0] = 2; a_dvc[1][0] = 1; a_tail[1][0] = 1;
        steps(2);
        a_rst = 0; step(); a_rst = 1;
        a_req[0][0] = 0; steps(3);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            a_rst = (c % 80 == 79) ? 0 : 1;
            for (int p = 0; p < P; p++) begin
                for (int v = 0; v < V; v++) begin
                    a_req[p][v]  = ($urandom % 3 != 0) ? 1 : 0;
                    a_out[p][v]  = int'($urandom % P);
                    a_dvc[p][v]  = int'($urandom % V);
                    a_tail[p][v] = ($urandom % 4 != 0) ? 1 : 0;
                    a_cred[p][v] = ($urandom % 6 == 0) ? 1 : 0;
                end
            end
            step();
        end

        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
